// File: rtl/mram_s_s_be_clr_if.sv
// User-side bus of the byte-enable RAM with clear engine.
// The master drives address, enables, data and flush; the slave returns read data and status.
interface mram_s_s_be_clr_if #(
    parameter int P_DW = 6,
    parameter int AW   = 6
);
    logic [AW-1:0]              ADDR;
    logic                       RE;
    logic [(1<<P_DW)/8-1:0]     WE;
    logic [(1<<P_DW)-1:0]       DIN;
    logic [(1<<P_DW)-1:0]       DOUT;
    logic                       DOUT_VLD;
    logic                       FLUSH;
    logic                       BUSY;

    modport master (
        output ADDR, RE, WE, DIN, FLUSH,
        input  DOUT, DOUT_VLD, BUSY
    );

    modport slave (
        input  ADDR, RE, WE, DIN, FLUSH,
        output DOUT, DOUT_VLD, BUSY
    );
endinterface

// File: rtl/mram_s_s_be_clr.sv
// Single-port RAM with per-byte write enables, a hardware clear sweep after reset/flush,
// read-first semantics and an optional output register stage.
module mram_s_s_be_clr #(
    parameter int         P_DW      = 6,
    parameter int         AW        = 6,
    parameter int         OREG      = 0,
    parameter logic [7:0] INIT_BYTE = 8'h00
) (
    input  logic               CLK,
    input  logic               RST,
    mram_s_s_be_clr_if.slave   bus
);
    localparam int DW    = 1 << P_DW;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] INIT_WORD = {NB{INIT_BYTE}};
    localparam logic [DW-1:0] X_WORD    = {(DW/2){2'b01}};

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_cnt, clr_cnt_nxt;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NB-1:0]   wr_be;
    logic            rd_en;
    logic [DW-1:0]   mem [DEPTH];
    logic            rd_vld;
    logic [DW-1:0]   rd_data;
    logic            out_vld;
    logic [DW-1:0]   out_data;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // The sweep owns the write port while clearing; user traffic and FLUSH are dropped.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        wr_en       = 1'b0;
        wr_addr     = bus.ADDR;
        wr_data     = bus.DIN;
        wr_be       = bus.WE;
        rd_en       = 1'b0;
        case (state)
            CLEAR: begin
                wr_en       = 1'b1;
                wr_addr     = clr_cnt;
                wr_data     = INIT_WORD;
                wr_be       = '1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == '1) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (bus.FLUSH) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end else begin
                    wr_en = |bus.WE;
                    rd_en = bus.RE;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Sampling the array with the same edge as the write gives read-first behaviour.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_vld <= rd_en;
            if (rd_en) begin
                rd_data <= mem[bus.ADDR];
            end
        end
    end

    generate
        if (OREG != 0) begin : g_oreg
            logic          pipe_vld;
            logic [DW-1:0] pipe_data;

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    pipe_vld  <= 1'b0;
                    pipe_data <= '0;
                end else begin
                    pipe_vld  <= rd_vld;
                    pipe_data <= rd_data;
                end
            end

            assign out_vld  = pipe_vld;
            assign out_data = pipe_data;
        end else begin : g_no_oreg
            assign out_vld  = rd_vld;
            assign out_data = rd_data;
        end
    endgenerate

    assign bus.DOUT     = out_vld ? out_data : X_WORD;
    assign bus.DOUT_VLD = out_vld;
    assign bus.BUSY     = (state == CLEAR);
endmodule

// File: tb/tb_mram_s_s_be_clr.sv
// Scoreboard bench: one DUT without and one with the output register share the same stimulus,
// and a negedge monitor checks each against expectations queued from a word-array model.
module tb_mram_s_s_be_clr;
    localparam int         P_DW  = 6;
    localparam int         AW    = 4;
    localparam int         DEPTH = 1 << AW;
    localparam logic [7:0] INIT  = 8'hA5;
    localparam logic [63:0] INIT_WORD = {8{INIT}};
    localparam logic [63:0] X_WORD    = 64'h5555555555555555;

    typedef struct {
        logic [63:0] data;
        int          due;
    } exp_t;

    logic        CLK;
    logic        rst_n;
    logic [3:0]  addr;
    logic        re;
    logic [7:0]  we;
    logic [63:0] din;
    logic        flush;

    int          checks;
    int          failures;
    int          edge_no;
    int          busy_left;
    logic [63:0] model_mem [DEPTH];
    exp_t        exp_q [2][$];

    logic [63:0] dout_a [2];
    logic        vld_a  [2];
    logic        busy_a [2];

    mram_s_s_be_clr_if #(.P_DW(P_DW), .AW(AW)) bus0 ();
    mram_s_s_be_clr_if #(.P_DW(P_DW), .AW(AW)) bus1 ();

    assign bus0.ADDR  = addr;
    assign bus0.RE    = re;
    assign bus0.WE    = we;
    assign bus0.DIN   = din;
    assign bus0.FLUSH = flush;
    assign bus1.ADDR  = addr;
    assign bus1.RE    = re;
    assign bus1.WE    = we;
    assign bus1.DIN   = din;
    assign bus1.FLUSH = flush;

    assign dout_a[0] = bus0.DOUT;
    assign dout_a[1] = bus1.DOUT;
    assign vld_a[0]  = bus0.DOUT_VLD;
    assign vld_a[1]  = bus1.DOUT_VLD;
    assign busy_a[0] = bus0.BUSY;
    assign busy_a[1] = bus1.BUSY;

    mram_s_s_be_clr #(.P_DW(P_DW), .AW(AW), .OREG(0), .INIT_BYTE(INIT)) u_dut0 (
        .CLK (CLK),
        .RST (rst_n),
        .bus (bus0)
    );

    mram_s_s_be_clr #(.P_DW(P_DW), .AW(AW), .OREG(1), .INIT_BYTE(INIT)) u_dut1 (
        .CLK (CLK),
        .RST (rst_n),
        .bus (bus1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic void check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
        end
    endfunction

    // Drives one cycle of inputs, then advances the model by the rules for that edge.
    task automatic apply_stimulus(input logic re_i, input logic [7:0] we_i, input logic [3:0] addr_i,
                                  input logic [63:0] din_i, input logic flush_i);
        re    = re_i;
        we    = we_i;
        addr  = addr_i;
        din   = din_i;
        flush = flush_i;
        @(posedge CLK);
        edge_no++;
        if (rst_n === 1'b0) begin
            busy_left = DEPTH;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT_WORD;
            end
        end else if (flush_i) begin
            busy_left = DEPTH;
        end else begin
            if (re_i) begin
                exp_q[0].push_back('{data: model_mem[addr_i], due: edge_no});
                exp_q[1].push_back('{data: model_mem[addr_i], due: edge_no + 1});
            end
            for (int b = 0; b < 8; b++) begin
                if (we_i[b]) model_mem[addr_i][8*b +: 8] = din_i[8*b +: 8];
            end
        end
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 8'h00, 4'd0, 64'd0, 1'b0);
    endtask

    task automatic reset_dut(input int cycles);
        rst_n     = 1'b0;
        busy_left = DEPTH;
        exp_q[0].delete();
        exp_q[1].delete();
        idle_cycles(cycles);
        rst_n = 1'b1;
    endtask

    task automatic measure_busy(input string name);
        int n;
        n = 0;
        while (busy_a[0] === 1'b1 && n < 40) begin
            idle_cycles(1);
            n++;
        end
        check_output(name, 64'(n), 64'(DEPTH));
    endtask

    always @(negedge CLK) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            check_output($sformatf("busy%0d", k), 64'(busy_a[k]), 64'((rst_n === 1'b0) || (busy_left > 0)));
            if (vld_a[k] === 1'b1) begin
                if (exp_q[k].size() == 0) begin
                    check_output($sformatf("spurious_vld%0d", k), 64'(vld_a[k]), 64'd0);
                end else begin
                    e = exp_q[k].pop_front();
                    check_output($sformatf("rdata%0d", k), dout_a[k], e.data);
                    check_output($sformatf("latency%0d", k), 64'(edge_no), 64'(e.due));
                end
            end else begin
                check_output($sformatf("invalid_dout%0d", k), dout_a[k], X_WORD);
                if (exp_q[k].size() != 0 && exp_q[k][0].due <= edge_no) begin
                    e = exp_q[k].pop_front();
                    check_output($sformatf("missing_vld%0d", k), 64'(vld_a[k]), 64'd1);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        edge_no   = 0;
        busy_left = DEPTH;
        rst_n     = 1'b0;
        re        = 1'b0;
        we        = 8'h00;
        addr      = 4'd0;
        din       = 64'd0;
        flush     = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'hx;

        reset_dut(3);
        measure_busy("init_busy_len");

        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, 8'h00, 4'(i), 64'd0, 1'b0);
        idle_cycles(2);

        apply_stimulus(1'b0, 8'h0F, 4'd3, 64'h1122334455667788, 1'b0);
        apply_stimulus(1'b1, 8'h00, 4'd3, 64'd0, 1'b0);
        idle_cycles(2);

        apply_stimulus(1'b0, 8'hFF, 4'd5, 64'd0, 1'b0);
        apply_stimulus(1'b1, 8'hFF, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        apply_stimulus(1'b1, 8'h00, 4'd5, 64'd0, 1'b0);
        idle_cycles(2);

        apply_stimulus(1'b0, 8'hFF, 4'd7, 64'h0000_0000_0000_DEAD, 1'b0);
        apply_stimulus(1'b1, 8'h00, 4'd7, 64'd0, 1'b0);
        apply_stimulus(1'b1, 8'hFF, 4'd8, 64'h1234_5678_9ABC_DEF0, 1'b1);
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(1'b1, 8'hFF, 4'(i), {$urandom, $urandom}, 1'(i == 4));
        end
        check_output("flush_busy_tail", 64'(busy_a[0]), 64'd1);
        apply_stimulus(1'b1, 8'h00, 4'd7, 64'd0, 1'b0);
        check_output("flush_done", 64'(busy_a[0]), 64'd0);
        apply_stimulus(1'b1, 8'h00, 4'd7, 64'd0, 1'b0);
        apply_stimulus(1'b1, 8'h00, 4'd8, 64'd0, 1'b0);
        idle_cycles(3);

        reset_dut(2);
        idle_cycles(9);
        reset_dut(2);
        measure_busy("restart_busy_len");

        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)),
                           ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                           4'($urandom), {$urandom, $urandom},
                           1'($urandom_range(0, 59) == 0));
        end
        apply_stimulus(1'b1, 8'hFF, 4'd2, 64'd0, 1'b0);
        reset_dut(1);
        idle_cycles(DEPTH + 4);

        check_output("queue0_empty", 64'(exp_q[0].size()), 64'd0);
        check_output("queue1_empty", 64'(exp_q[1].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mram_s_s_be_clr.md
Name: mram_s_s_be_clr

Overview:
- Parametrised single-port synchronous RAM with per-byte write enables and a built-in hardware clear engine.
- The clear engine sweeps every word to a fixed init value after reset, and again on request.
- Adds an optional output pipeline register and a read-data-valid flag.
- Used for cache tag/valid arrays and predictor tables that must start from a known state without a software clear loop.

Parameters:
- P_DW, 6, log2 of data width in bits (minimum 3; 6 gives 64-bit words).
- AW, 6, address width; depth = 1<<AW words.
- OREG, 0, 1 inserts an output register stage, which adds one cycle of read latency.
- INIT_BYTE, 8'h00, byte replicated across the word and written by the clear engine.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- ADDR  in  AW  word address for the user read/write.
- RE  in  1  read request.
- WE  in  (1<<P_DW)/8  per-byte write enable; bit i covers DIN[8i+7:8i].
- DIN  in  1<<P_DW  write data.
- DOUT  out  1<<P_DW  read data.
- DOUT_VLD  out  1  DOUT carries valid read data this cycle.
- FLUSH  in  1  single-cycle pulse requesting a full re-clear.
- BUSY  out  1  clear in progress; user accesses are ignored.

Behaviour:
- State machine states: IDLE and CLEAR. A clear counter clr_cnt is AW bits wide.
- Reset (RST low, async):
  - state=CLEAR, clr_cnt=0, BUSY=1, DOUT_VLD=0.
  - Pipeline registers are 0.
  - Memory contents are not reset directly; the clear engine overwrites them.
- CLEAR:
  - Every cycle, write {(1<<P_DW)/8{INIT_BYTE}} to mem[clr_cnt], then clr_cnt+1.
  - When clr_cnt==all-ones is written, the next state is IDLE and clr_cnt wraps to 0.
  - From RST deassertion to BUSY=0 takes exactly 1<<AW cycles; BUSY falls on the edge after the last write.
- In CLEAR:
  - RE, WE and FLUSH are ignored; no user write occurs and no read is launched.
  - FLUSH does not restart the sweep.
- IDLE:
  - FLUSH=1 moves the state to CLEAR next edge with clr_cnt=0; BUSY=1 from that edge.
  - If FLUSH is high together with RE/WE in the same cycle, FLUSH wins and the user access is dropped (no write, no DOUT_VLD).
- Write (IDLE, FLUSH=0): on the edge, for each i with WE[i]=1, mem[ADDR] byte i <= DIN byte i. Other bytes are unchanged.
- Read (IDLE, FLUSH=0, RE=1 at cycle t):
  - Data is sampled at edge t.
  - OREG=0: DOUT/DOUT_VLD are valid in cycle t+1.
  - OREG=1: DOUT/DOUT_VLD are valid in cycle t+2.
  - Back-to-back reads are fully pipelined, one per cycle.
- Read and write to the same address in the same cycle is read-first: DOUT returns the pre-write word; the write still takes effect.
- Reads already in flight when FLUSH is accepted complete normally with pre-clear data.
- DOUT_VLD=0 forces DOUT to the uncertain pattern {(1<<P_DW)/2{2'b01}}. Consumers must qualify DOUT with DOUT_VLD.
- RE=0 does not hold the previous data.
- Asserting reset mid-clear or mid-read aborts the operation: the sweep restarts from 0 and in-flight reads are discarded (DOUT_VLD=0).

Test Plan:
- Reset and clear, P_DW=6, AW=4, INIT_BYTE=8'hA5:
  - Release RST and count cycles: BUSY stays 1 for exactly 16 cycles, then drops.
  - Read all 16 addresses: each returns 64'hA5A5A5A5A5A5A5A5 with DOUT_VLD=1.
- Byte-enable write:
  - After init 0, write ADDR=3, DIN=64'h1122334455667788, WE=8'b00001111.
  - Read ADDR=3 -> 64'h0000000055667788.
- Latency and read-first:
  - OREG=0: RE at cycle t gives DOUT_VLD in t+1. OREG=1: DOUT_VLD in t+2.
  - Same-cycle RE+WE(8'hFF) to ADDR=5 holding 0x0 with DIN 0xFFFF… -> DOUT=0. A following read returns all-ones.
- Flush:
  - Write ADDR=7=0xDEAD, then pulse FLUSH together with WE at ADDR=8.
  - BUSY is high for 16 cycles; RE/WE issued while busy are ignored.
  - Afterwards ADDR=7 reads INIT and ADDR=8 was never written.
- Invalid output: with RE=0, DOUT=64'h5555555555555555 and DOUT_VLD=0.
- Reset mid-clear: assert RST at clr_cnt=9 -> BUSY stays 1 and a full 16-cycle sweep restarts after release.
